// File: rtl/laser_scheduler_if.sv
// Signal bundle between the fire/frame-timing logic and laser_scheduler.
// Defining LASER_STATS_EN adds the shot and drop counters to the bundle.
interface laser_scheduler_if #(
    parameter int N_SLOTS = 4
);
    logic                    tick;
    logic                    pause;
    logic                    fire_top;
    logic                    fire_bot;
    logic                    ack_top;
    logic                    ack_bot;
    logic [N_SLOTS-1:0]      slot_active;
    logic [N_SLOTS-1:0]      slot_dir;
    logic [10*N_SLOTS-1:0]   slot_y;
    logic                    busy;
`ifdef LASER_STATS_EN
    logic [15:0]             shots_top;
    logic [15:0]             shots_bot;
    logic [15:0]             dropped;

    modport master (
        output tick, pause, fire_top, fire_bot,
        input  ack_top, ack_bot, slot_active, slot_dir, slot_y, busy,
               shots_top, shots_bot, dropped
    );
    modport slave (
        input  tick, pause, fire_top, fire_bot,
        output ack_top, ack_bot, slot_active, slot_dir, slot_y, busy,
               shots_top, shots_bot, dropped
    );
`else
    modport master (
        output tick, pause, fire_top, fire_bot,
        input  ack_top, ack_bot, slot_active, slot_dir, slot_y, busy
    );
    modport slave (
        input  tick, pause, fire_top, fire_bot,
        output ack_top, ack_bot, slot_active, slot_dir, slot_y, busy
    );
`endif
endinterface

// File: rtl/laser_scheduler.sv
// Shared laser-slot pool: per-cannon cooldown, round-robin slot grants, per-tick movement.
// Optional LASER_STATS_EN adds saturating shots_top/shots_bot/dropped counters.
module laser_scheduler #(
    parameter int N_SLOTS     = 4,
    parameter int SPEED       = 4,
    parameter int COOLDOWN    = 8,
    parameter int TOP_START_Y = 232,
    parameter int BOT_START_Y = 330,
    parameter int Y_MAX       = 479
) (
    input  logic             clk,
    input  logic             rst,
    laser_scheduler_if.slave bus
);
    localparam int         IDX_W      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [9:0] SPEED_Y    = 10'(SPEED);
    localparam logic [9:0] TOP_Y      = 10'(TOP_START_Y);
    localparam logic [9:0] BOT_Y      = 10'(BOT_START_Y);
    localparam logic [9:0] DOWN_LIMIT = 10'(Y_MAX - SPEED);
    localparam logic [7:0] COOL_LOAD  = 8'(COOLDOWN);
    localparam logic [0:0] READY      = 1'b0;
    localparam logic [0:0] COOL       = 1'b1;
    localparam int         TOP        = 0;
    localparam int         BOT        = 1;

    logic [N_SLOTS-1:0] active_q, active_d;
    logic [N_SLOTS-1:0] dir_q, dir_d;
    logic [9:0]         y_q [N_SLOTS];
    logic [9:0]         y_d [N_SLOTS];
    logic [1:0]         state_q, state_d;
    logic [7:0]         cool_q [2];
    logic [7:0]         cool_d [2];
    logic               prio_q, prio_d;
    logic [1:0]         ack_q;

    logic               advance;
    logic               elig_top, elig_bot;
    logic               first_found, second_found;
    logic [IDX_W-1:0]   first_idx, second_idx;
    logic [1:0]         grant;
    logic [IDX_W-1:0]   top_idx, bot_idx;
    logic               refused;

    assign advance  = bus.tick & ~bus.pause;
    assign elig_top = bus.fire_top & (state_q[TOP] == READY) & ~bus.pause;
    assign elig_bot = bus.fire_bot & (state_q[BOT] == READY) & ~bus.pause;

    // Lowest and second-lowest free slot, from the registered valid bits only.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!active_q[i]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = IDX_W'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        grant   = 2'b00;
        top_idx = first_idx;
        bot_idx = first_idx;
        prio_d  = prio_q;
        refused = 1'b0;
        if (elig_top && elig_bot) begin
            if (second_found) begin
                grant   = 2'b11;
                bot_idx = second_idx;
            end else if (first_found) begin
                // Contested single slot: holder wins, priority passes to the other cannon.
                grant   = prio_q ? 2'b10 : 2'b01;
                prio_d  = ~prio_q;
                refused = 1'b1;
            end else begin
                refused = 1'b1;
            end
        end else if (elig_top) begin
            grant[TOP] = first_found;
            refused    = ~first_found;
        end else if (elig_bot) begin
            grant[BOT] = first_found;
            refused    = ~first_found;
        end
    end

    always_comb begin
        active_d = active_q;
        dir_d    = dir_q;
        y_d      = y_q;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (advance && active_q[i]) begin
                if (!dir_q[i]) begin
                    if (y_q[i] < SPEED_Y) active_d[i] = 1'b0;
                    else                  y_d[i] = y_q[i] - SPEED_Y;
                end else begin
                    if (y_q[i] > DOWN_LIMIT) active_d[i] = 1'b0;
                    else                     y_d[i] = y_q[i] + SPEED_Y;
                end
            end
        end
        // Granted slots were inactive, so they never collide with the movement above.
        if (grant[TOP]) begin
            active_d[top_idx] = 1'b1;
            dir_d[top_idx]    = 1'b0;
            y_d[top_idx]      = TOP_Y;
        end
        if (grant[BOT]) begin
            active_d[bot_idx] = 1'b1;
            dir_d[bot_idx]    = 1'b1;
            y_d[bot_idx]      = BOT_Y;
        end
    end

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        for (int c = 0; c < 2; c++) begin
            case (state_q[c])
                READY: begin
                    if (grant[c]) begin
                        state_d[c] = COOL;
                        cool_d[c]  = COOL_LOAD;
                    end
                end
                COOL: begin
                    if (advance) begin
                        cool_d[c] = cool_q[c] - 8'd1;
                        if (cool_q[c] == 8'd1) state_d[c] = READY;
                    end
                end
                default: state_d[c] = READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            active_q <= '0;
            dir_q    <= '0;
            state_q  <= {READY, READY};
            prio_q   <= 1'b0;
            ack_q    <= 2'b00;
            // NOTE: the y array is small and renderer-visible, so it is reset rather than left unknown.
            for (int i = 0; i < N_SLOTS; i++) y_q[i] <= '0;
            for (int c = 0; c < 2; c++) cool_q[c] <= '0;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            y_q      <= y_d;
            state_q  <= state_d;
            cool_q   <= cool_d;
            prio_q   <= prio_d;
            ack_q    <= grant;
        end
    end

    assign bus.ack_top     = ack_q[TOP];
    assign bus.ack_bot     = ack_q[BOT];
    assign bus.slot_active = active_q;
    assign bus.slot_dir    = dir_q;
    assign bus.busy        = |active_q;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_y
        assign bus.slot_y[10*i +: 10] = y_q[i];
    end

`ifdef LASER_STATS_EN
    logic [15:0] shots_top_q, shots_bot_q, dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shots_top_q <= '0;
            shots_bot_q <= '0;
            dropped_q   <= '0;
        end else begin
            if (grant[TOP] && shots_top_q != 16'hFFFF) shots_top_q <= shots_top_q + 16'd1;
            if (grant[BOT] && shots_bot_q != 16'hFFFF) shots_bot_q <= shots_bot_q + 16'd1;
            if (refused && dropped_q != 16'hFFFF)      dropped_q   <= dropped_q + 16'd1;
        end
    end

    assign bus.shots_top = shots_top_q;
    assign bus.shots_bot = shots_bot_q;
    assign bus.dropped   = dropped_q;
`else
    logic unused_refused;
    assign unused_refused = refused;
`endif
endmodule
